// File: rtl/rw_manager_ac_pkg.sv
// Shared definitions for the RW manager AC issue stage: AC word field
// positions, pin widths, the NOP command and the issue FSM states.
package rw_manager_ac_pkg;

  localparam int MEM_ADDR_W = 16;
  localparam int MEM_BA_W   = 3;

  localparam int CMD_HI  = 27;
  localparam int CMD_LO  = 24;
  localparam int BA_HI   = 22;
  localparam int BA_LO   = 20;
  localparam int ODT     = 18;
  localparam int RESETN  = 17;
  localparam int CKE     = 16;
  localparam int ADDR_HI = 15;
  localparam int ADDR_LO = 0;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] NOP_CMD = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_GAP,
    ST_DONE
  } ac_state_t;

endpackage

// File: rtl/rw_manager_ac_decode.sv
// Splits a 32-bit AC ROM word into pin fields and flags words that must
// never reach the memory (reserved top nibble set, or an unprogrammed zero).
module rw_manager_ac_decode
  import rw_manager_ac_pkg::*;
(
  input  logic [31:0]           word,
  output logic [3:0]            cmd,
  output logic [MEM_BA_W-1:0]   ba,
  output logic [MEM_ADDR_W-1:0] addr,
  output logic                  odt,
  output logic                  reset_n,
  output logic                  cke,
  output logic                  illegal
);

  logic unused_bits;

  assign cmd     = word[CMD_HI:CMD_LO];
  assign ba      = word[BA_HI:BA_LO];
  assign addr    = word[ADDR_HI:ADDR_LO];
  assign odt     = word[ODT];
  assign reset_n = word[RESETN];
  assign cke     = word[CKE];
  assign illegal = (word[31:28] != 4'd0) || (word == 32'd0);

  assign unused_bits = ^{word[23], word[19]};

endmodule

// File: rtl/rw_manager_ac_issue.sv
// AC issue stage: fetches one AC word from the registered ROM, then replays
// it cmd_count+1 times with cmd_gap NOP cycles after each issue.
//
// state | meaning
// IDLE  | ready for a request, command pins NOP
// FETCH | waiting ROM_LATENCY+1 cycles for rom_q, then capture
// ISSUE | one cycle with the captured command on the pins
// GAP   | NOP cycles after an issue; non-command pins hold
// DONE  | one-cycle completion pulse
module rw_manager_ac_issue
  import rw_manager_ac_pkg::*;
#(
  parameter int ROM_ADDR_W  = 6,
  parameter int ROM_LATENCY = 2,
  parameter int CNT_W       = 8,
  parameter int GAP_W       = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ROM_ADDR_W-1:0] cmd_index,
  input  logic [CNT_W-1:0]      cmd_count,
  input  logic [GAP_W-1:0]      cmd_gap,
  output logic [ROM_ADDR_W-1:0] rom_rdaddress,
  input  logic [31:0]           rom_q,
  output logic                  mem_cs_n,
  output logic                  mem_ras_n,
  output logic                  mem_cas_n,
  output logic                  mem_we_n,
  output logic [MEM_BA_W-1:0]   mem_ba,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic                  mem_odt,
  output logic                  mem_cke,
  output logic                  mem_reset_n,
  output logic                  done,
  output logic                  err
);

  localparam int FCNT_W = (ROM_LATENCY < 1) ? 1 : $clog2(ROM_LATENCY + 1);

  ac_state_t state, state_nxt;

  logic [FCNT_W-1:0] fetch_cnt;
  logic [CNT_W-1:0]  rep_cnt;
  logic [GAP_W-1:0]  gap_len;
  logic [GAP_W-1:0]  gap_cnt;

  logic [3:0]            cmd_q;
  logic [MEM_BA_W-1:0]   ba_q;
  logic [MEM_ADDR_W-1:0] addr_q;
  logic                  odt_q, cke_q, reset_n_q;

  logic [3:0]            dec_cmd;
  logic [MEM_BA_W-1:0]   dec_ba;
  logic [MEM_ADDR_W-1:0] dec_addr;
  logic                  dec_odt, dec_reset_n, dec_cke, dec_illegal;
  logic [3:0]            pins_cmd;

  rw_manager_ac_decode u_decode (
    .word    (rom_q),
    .cmd     (dec_cmd),
    .ba      (dec_ba),
    .addr    (dec_addr),
    .odt     (dec_odt),
    .reset_n (dec_reset_n),
    .cke     (dec_cke),
    .illegal (dec_illegal)
  );

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    done      = 1'b0;
    pins_cmd  = NOP_CMD;
    case (state)
      ST_IDLE: begin
        cmd_ready = !reset;
        if (cmd_valid) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (fetch_cnt == '0) state_nxt = dec_illegal ? ST_DONE : ST_ISSUE;
      end
      ST_ISSUE: begin
        pins_cmd = cmd_q;
        if (gap_len != '0)      state_nxt = ST_GAP;
        else if (rep_cnt == '0) state_nxt = ST_DONE;
      end
      ST_GAP: begin
        if (gap_cnt == '0) state_nxt = (rep_cnt == '0) ? ST_DONE : ST_ISSUE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      rom_rdaddress <= '0;
      fetch_cnt     <= '0;
      rep_cnt       <= '0;
      gap_len       <= '0;
      gap_cnt       <= '0;
      err           <= 1'b0;
      cmd_q         <= NOP_CMD;
      ba_q          <= '0;
      addr_q        <= '0;
      odt_q         <= 1'b0;
      cke_q         <= 1'b0;
      reset_n_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            rom_rdaddress <= cmd_index;
            rep_cnt       <= cmd_count;
            gap_len       <= cmd_gap;
            fetch_cnt     <= FCNT_W'(ROM_LATENCY);
            err           <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (fetch_cnt != '0) begin
            fetch_cnt <= fetch_cnt - 1'b1;
          end else if (dec_illegal) begin
            err <= 1'b1;
          end else begin
            cmd_q     <= dec_cmd;
            ba_q      <= dec_ba;
            addr_q    <= dec_addr;
            odt_q     <= dec_odt;
            cke_q     <= dec_cke;
            reset_n_q <= dec_reset_n;
          end
        end
        ST_ISSUE: begin
          if (gap_len != '0)      gap_cnt <= gap_len - 1'b1;
          else if (rep_cnt != '0) rep_cnt <= rep_cnt - 1'b1;
        end
        ST_GAP: begin
          if (gap_cnt != '0)      gap_cnt <= gap_cnt - 1'b1;
          else if (rep_cnt != '0) rep_cnt <= rep_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Repeats replay the captured word; only the command pins fall back to NOP.
  assign {mem_cs_n, mem_ras_n, mem_cas_n, mem_we_n} = pins_cmd;
  assign mem_ba      = ba_q;
  assign mem_addr    = addr_q;
  assign mem_odt     = odt_q;
  assign mem_cke     = cke_q;
  assign mem_reset_n = reset_n_q;

endmodule

// File: tb/tb_rw_manager_ac_issue.sv
// Directed bench for rw_manager_ac_issue with a two-stage registered ROM
// model; expected pin values are hand-decoded from the ROM contents.
module tb_rw_manager_ac_issue;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_index;
  logic [7:0]  cmd_count;
  logic [3:0]  cmd_gap;
  logic [5:0]  rom_rdaddress;
  logic [31:0] rom_q;
  logic        mem_cs_n, mem_ras_n, mem_cas_n, mem_we_n;
  logic [2:0]  mem_ba;
  logic [15:0] mem_addr;
  logic        mem_odt, mem_cke, mem_reset_n;
  logic        done, err;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  rw_manager_ac_issue dut (
    .clock         (clock),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_index     (cmd_index),
    .cmd_count     (cmd_count),
    .cmd_gap       (cmd_gap),
    .rom_rdaddress (rom_rdaddress),
    .rom_q         (rom_q),
    .mem_cs_n      (mem_cs_n),
    .mem_ras_n     (mem_ras_n),
    .mem_cas_n     (mem_cas_n),
    .mem_we_n      (mem_we_n),
    .mem_ba        (mem_ba),
    .mem_addr      (mem_addr),
    .mem_odt       (mem_odt),
    .mem_cke       (mem_cke),
    .mem_reset_n   (mem_reset_n),
    .done          (done),
    .err           (err)
  );

  // Two-stage registered AC ROM; unprogrammed entries read as zero.
  logic [31:0] rom_mem [64];
  logic [31:0] rom_s1;
  initial begin
    for (int i = 0; i < 64; i++) rom_mem[i] = 32'd0;
    rom_mem[6'h04] = 32'h0600_0433;
    rom_mem[6'h05] = 32'h0D5F_1234;
    rom_mem[6'h06] = 32'h1F00_0000;
    rom_mem[6'h07] = 32'h0E7B_00FF;
    rom_mem[6'h10] = 32'h0799_0000;
  end
  always @(posedge clock) begin
    rom_s1 <= rom_mem[rom_rdaddress];
    rom_q  <= rom_s1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [5:0]  idx;
    logic [7:0]  count;
    logic [3:0]  gap;
    logic        legal;
    logic [3:0]  cmd;
    logic [2:0]  ba;
    logic [15:0] addr;
    logic        odt;
    logic        cke;
    logic        rn;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] pins_cmd();
    return {mem_cs_n, mem_ras_n, mem_cas_n, mem_we_n};
  endfunction

  task automatic check_reset_pins(input string tag);
    chk({tag, "_cmd"}, int'(pins_cmd()), 'hF);
    chk({tag, "_ba"}, int'(mem_ba), 0);
    chk({tag, "_addr"}, int'(mem_addr), 0);
    chk({tag, "_odt"}, int'(mem_odt), 0);
    chk({tag, "_cke"}, int'(mem_cke), 0);
    chk({tag, "_rn"}, int'(mem_reset_n), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_ready"}, int'(cmd_ready), 0);
    chk({tag, "_romaddr"}, int'(rom_rdaddress), 0);
  endtask

  // Cycle t=1 is the cycle after the accept edge; first issue is at t=4.
  task automatic run_req(input vec_t v, input bit keep);
    int c, g, done_t, issues;
    bit issue;
    c = int'(v.count);
    g = int'(v.gap);
    done_t = v.legal ? 4 + (c + 1) * (g + 1) : 4;
    issues = 0;
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_index = v.idx;
    cmd_count = v.count;
    cmd_gap   = v.gap;
    chk("ready_before_accept", int'(cmd_ready), 1);
    for (int t = 1; t <= done_t; t++) begin
      @(negedge clock);
      if (t == 1 && !keep) cmd_valid = 1'b0;
      if (t == done_t && keep) cmd_valid = 1'b0;
      issue = v.legal && t >= 4 && t < done_t && ((t - 4) % (g + 1) == 0);
      if (pins_cmd() != 4'hF) issues++;
      chk("cmd_pins", int'(pins_cmd()), issue ? int'(v.cmd) : 'hF);
      chk("done", int'(done), int'(t == done_t));
      chk("ready_busy", int'(cmd_ready), 0);
      chk("rom_rdaddress", int'(rom_rdaddress), int'(v.idx));
      chk("err", int'(err), (t >= 4) ? int'(!v.legal) : 0);
      if (t >= 4) begin
        chk("ba", int'(mem_ba), int'(v.ba));
        chk("addr", int'(mem_addr), int'(v.addr));
        chk("odt", int'(mem_odt), int'(v.odt));
        chk("cke", int'(mem_cke), int'(v.cke));
        chk("reset_n", int'(mem_reset_n), int'(v.rn));
      end
    end
    chk("issue_count", issues, v.legal ? c + 1 : 0);
  endtask

  initial begin
    vecs[0] = '{6'h04, 8'd0, 4'd0, 1'b1, 4'b0110, 3'd0, 16'h0433, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{6'h10, 8'd2, 4'd3, 1'b1, 4'b0111, 3'd1, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{6'h1F, 8'd1, 4'd1, 1'b0, 4'b1111, 3'd1, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{6'h05, 8'd1, 4'd0, 1'b1, 4'b1101, 3'd5, 16'h1234, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{6'h3F, 8'd0, 4'd2, 1'b0, 4'b1111, 3'd5, 16'h1234, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{6'h06, 8'd0, 4'd0, 1'b0, 4'b1111, 3'd5, 16'h1234, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{6'h07, 8'd4, 4'd1, 1'b1, 4'b1110, 3'd7, 16'h00FF, 1'b0, 1'b1, 1'b1};

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_index = '0;
    cmd_count = '0;
    cmd_gap   = '0;
    repeat (3) @(negedge clock);
    check_reset_pins("por");
    reset = 1'b0;
    @(negedge clock);
    chk("ready_after_reset", int'(cmd_ready), 1);
    chk("idle_cmd", int'(pins_cmd()), 'hF);

    for (int i = 0; i < 7; i++) run_req(vecs[i], 1'b0);

    // cmd_valid held across two requests: second accepted right after done.
    run_req(vecs[0], 1'b1);
    run_req(vecs[1], 1'b1);

    // Largest repeat count: 256 back-to-back issues.
    begin
      vec_t big;
      big = vecs[3];
      big.count = 8'hFF;
      big.gap   = 4'd0;
      run_req(big, 1'b0);
    end

    // Reset during the second GAP of a count=3, gap=2 request.
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_index = 6'h10;
    cmd_count = 8'd3;
    cmd_gap   = 4'd2;
    chk("rst_ready_before", int'(cmd_ready), 1);
    for (int t = 1; t <= 8; t++) begin
      @(negedge clock);
      if (t == 1) cmd_valid = 1'b0;
      if (t == 7) chk("rst_second_issue", int'(pins_cmd()), 'h7);
      if (t == 8) chk("rst_in_gap", int'(pins_cmd()), 'hF);
    end
    reset = 1'b1;
    @(negedge clock);
    check_reset_pins("midrst");
    reset = 1'b0;
    @(negedge clock);
    chk("ready_after_midrst", int'(cmd_ready), 1);
    for (int t = 0; t < 20; t++) begin
      chk("no_done_after_rst", int'(done), 0);
      chk("no_cmd_after_rst", int'(pins_cmd()), 'hF);
      @(negedge clock);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
